// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retirement trace buffer: record layout, capture states, control-FSM state codes.
// Record gains a ts field when RETIRE_TRACE_TIMESTAMP_EN is defined.
package retire_trace_buffer_pkg;

  localparam logic [4:0] FETCH  = 5'h00;
  localparam logic [4:0] DECODE = 5'h01;

  typedef enum logic {
    IDLE,
    COLLECT
  } trace_state_t;

  typedef struct packed {
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } retire_rec_t;

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Valid/ready stream carrying retired-instruction records out of the trace buffer.
interface retire_trace_buffer_if;
  import retire_trace_buffer_pkg::*;

  logic        trace_valid;
  logic        trace_ready;
  retire_rec_t trace_rec;

  modport master (output trace_valid, output trace_rec, input trace_ready);
  modport slave  (input trace_valid, input trace_rec, output trace_ready);

endinterface

// File: rtl/retire_trace_buffer_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and a separate occupancy counter.
// Head data reads as zero while empty so idle outputs stay clean.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wr_data,
  input  logic                   pop,
  output T                       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level_q;
  logic           do_push;
  logic           do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign level   = level_q;
  assign rd_data = empty ? T'('0) : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: builds one record per instruction from core taps and queues it for drain.
// Optional RETIRE_TRACE_TIMESTAMP_EN adds a free-running cycle counter stamped into each record.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trace_en,
  input  logic [4:0]             fsm_state,
  input  logic [31:0]            pc_instr,
  input  logic [31:0]            instruction,
  input  logic                   reg_write,
  input  logic [4:0]             rd,
  input  logic [31:0]            result,
  input  logic                   mem_write,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  retire_trace_buffer_if.master  trace,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);

  trace_state_t state_q, state_d;
  retire_rec_t  cur_q, cur_d, rec_next, commit_rec, head_rec;
  logic [31:0]  seq_q;
  logic         commit, latch, drop;
  logic         pop_fire, fifo_full, fifo_empty;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DECODE always opens a new record; when one is already open it is committed on that same edge.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    latch   = 1'b0;
    if (!trace_en) begin
      state_d = IDLE;
    end else begin
      if (state_q == COLLECT && fsm_state == FETCH) begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      if (fsm_state == DECODE) begin
        latch   = 1'b1;
        state_d = COLLECT;
        if (state_q == COLLECT) commit = 1'b1;
      end
    end
  end

  // Writes seen in the commit cycle still land in the outgoing record.
  always_comb begin
    rec_next = cur_q;
    if (state_q == COLLECT) begin
      if (reg_write && rd != 5'd0) begin
        rec_next.rd_we   = 1'b1;
        rec_next.rd      = rd;
        rec_next.rd_data = result;
      end
      if (mem_write) begin
        rec_next.mem_we   = 1'b1;
        rec_next.mem_addr = mem_addr;
        rec_next.mem_data = mem_wdata;
      end
    end

    commit_rec     = rec_next;
    commit_rec.seq = seq_q;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    commit_rec.ts  = cycle_q;
`endif

    cur_d = rec_next;
    if (latch) begin
      cur_d       = '0;
      cur_d.pc    = pc_instr;
      cur_d.instr = instruction;
    end
  end

  assign pop_fire = trace.trace_valid & trace.trace_ready;
  assign drop     = commit & fifo_full & ~pop_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q      <= '0;
      seq_q      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      cur_q <= cur_d;
      if (commit) seq_q <= seq_q + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  sync_fifo #(
    .T     (retire_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (commit),
    .wr_data (commit_rec),
    .pop     (pop_fire),
    .rd_data (head_rec),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign trace.trace_valid = ~fifo_empty;
  assign trace.trace_rec   = head_rec;

endmodule
